// File: rtl/music_player_mcu.sv
// rtl/music_player_mcu.sv - play/pause/skip sequencer driving song select, play level and reader reset
// Moore FSM; song index and resume flag are the only datapath state.
module music_player_mcu #(
  parameter int N_SONGS   = 4,
  parameter int SONG_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_pause,
  input  logic                 next,
  input  logic                 prev,
  input  logic                 song_done,
  input  logic                 continuous,
  output logic                 play,
  output logic                 reset_player,
  output logic [SONG_BITS-1:0] song
);

  typedef enum logic [2:0] {
    RESET_PLAY = 3'd0,
    PAUSED     = 3'd1,
    PLAYING    = 3'd2,
    NEXT_SONG  = 3'd3,
    PREV_SONG  = 3'd4
  } state_t;

  localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(N_SONGS - 1);

  state_t               state, state_next;
  logic                 resume, resume_next;
  logic [SONG_BITS-1:0] song_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RESET_PLAY;
      resume <= 1'b0;
      song   <= '0;
    end else begin
      state  <= state_next;
      resume <= resume_next;
      song   <= song_next;
    end
  end

  always_comb begin
    state_next  = RESET_PLAY;
    resume_next = resume;
    song_next   = song;
    case (state)
      RESET_PLAY: state_next = resume ? PLAYING : PAUSED;
      PAUSED: begin
        state_next = PAUSED;
        if (next) begin
          state_next  = NEXT_SONG;
          resume_next = 1'b0;
        end else if (prev) begin
          state_next  = PREV_SONG;
          resume_next = 1'b0;
        end else if (play_pause) begin
          state_next = PLAYING;
        end
      end
      PLAYING: begin
        state_next = PLAYING;
        if (song_done) begin
          // continuous mode advances; otherwise rewind the same song and stop
          state_next  = continuous ? NEXT_SONG : RESET_PLAY;
          resume_next = continuous;
        end else if (next) begin
          state_next  = NEXT_SONG;
          resume_next = 1'b1;
        end else if (prev) begin
          state_next  = PREV_SONG;
          resume_next = 1'b1;
        end else if (play_pause) begin
          state_next = PAUSED;
        end
      end
      NEXT_SONG: begin
        state_next = RESET_PLAY;
        song_next  = (song == LAST_SONG) ? '0 : song + 1'b1;
      end
      PREV_SONG: begin
        state_next = RESET_PLAY;
        song_next  = (song == '0) ? LAST_SONG : song - 1'b1;
      end
      default: state_next = RESET_PLAY;
    endcase
  end

  assign play         = (state == PLAYING);
  assign reset_player = (state == RESET_PLAY);

endmodule

// File: tb/tb_music_player_mcu.sv
// tb/tb_music_player_mcu.sv - directed self-checking bench for music_player_mcu
module tb_music_player_mcu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_pause = 1'b0;
  logic       next = 1'b0;
  logic       prev = 1'b0;
  logic       song_done = 1'b0;
  logic       continuous = 1'b0;
  logic       play;
  logic       reset_player;
  logic [1:0] song;

  int total = 0;
  int bad = 0;

  music_player_mcu #(.N_SONGS(4), .SONG_BITS(2)) dut (
    .clk(clk),
    .reset(reset),
    .play_pause(play_pause),
    .next(next),
    .prev(prev),
    .song_done(song_done),
    .continuous(continuous),
    .play(play),
    .reset_player(reset_player),
    .song(song)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int e_play, input int e_rp, input int e_song);
    check({tag, ".play"}, 32'(play), 32'(e_play));
    check({tag, ".reset_player"}, 32'(reset_player), 32'(e_rp));
    check({tag, ".song"}, 32'(song), 32'(e_song));
  endtask

  task automatic pulse_pp();   play_pause = 1'b1; tick(); play_pause = 1'b0; endtask
  task automatic pulse_next(); next = 1'b1;       tick(); next = 1'b0;       endtask
  task automatic pulse_prev(); prev = 1'b1;       tick(); prev = 1'b0;       endtask

  initial begin
    // reset held across edges
    @(negedge clk);
    outs("in_reset", 0, 1, 0);
    tick();
    outs("in_reset_edge", 0, 1, 0);
    reset = 1'b0;
    #1 outs("after_release", 0, 1, 0);
    tick();
    outs("paused", 0, 0, 0);
    tick(); tick(); tick();
    outs("paused_held", 0, 0, 0);

    // play / pause toggling
    pulse_pp();
    outs("play_on", 1, 0, 0);
    tick();
    outs("play_held", 1, 0, 0);
    pulse_pp();
    outs("play_off", 0, 0, 0);

    // prev from paused song 0 wraps to 3 and stays paused
    pulse_prev();
    outs("prev_p.t1", 0, 0, 0);
    tick();
    outs("prev_p.t2", 0, 1, 3);
    tick();
    outs("prev_p.t3", 0, 0, 3);
    tick();
    outs("prev_p.t4", 0, 0, 3);

    // next from playing song 3 wraps to 0; a pulse during NEXT_SONG is dropped
    pulse_pp();
    outs("play_s3", 1, 0, 3);
    pulse_next();
    outs("next_w.t1", 0, 0, 3);
    next = 1'b1; tick(); next = 1'b0;
    outs("next_w.t2", 0, 1, 0);
    tick();
    outs("next_w.t3", 1, 0, 0);
    tick();
    outs("next_w.t4", 1, 0, 0);

    // advance to song 1 while playing
    pulse_next(); tick(); tick();
    outs("to_s1", 1, 0, 1);

    // continuous: song_done held 3 cycles advances exactly once
    continuous = 1'b1;
    song_done = 1'b1;
    tick();
    outs("cont.t1", 0, 0, 1);
    tick();
    outs("cont.t2", 0, 1, 2);
    tick();
    outs("cont.t3", 1, 0, 2);
    song_done = 1'b0;
    tick();
    outs("cont.t4", 1, 0, 2);

    // back to song 1 via prev while playing
    pulse_prev(); tick(); tick();
    outs("prev_play", 1, 0, 1);

    // non-continuous: rewind and stop
    continuous = 1'b0;
    song_done = 1'b1;
    tick();
    song_done = 1'b0;
    outs("rewind.t1", 0, 1, 1);
    tick();
    outs("rewind.t2", 0, 0, 1);
    tick();
    outs("rewind.t3", 0, 0, 1);

    // song_done + next + play_pause together: song_done path only
    pulse_pp();
    outs("play_s1", 1, 0, 1);
    continuous = 1'b1;
    song_done = 1'b1; next = 1'b1; play_pause = 1'b1;
    tick();
    song_done = 1'b0; next = 1'b0; play_pause = 1'b0;
    outs("simul.t1", 0, 0, 1);
    tick();
    outs("simul.t2", 0, 1, 2);
    tick();
    outs("simul.t3", 1, 0, 2);

    // asynchronous reset in the middle of NEXT_SONG
    pulse_next();
    outs("pre_areset", 0, 0, 2);
    #2 reset = 1'b1;
    #1 outs("areset", 0, 1, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    outs("areset_after", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/music_player_mcu.md
Name: music_player_mcu

Overview:
Top-level sequencing controller for the note-reader/player datapath. It turns debounced single-cycle button pulses (play/pause, next, previous) and the reader's song_done flag into three outputs: the song-select bus, the play level and a reader/player reset pulse. It sits between the button debouncers and the song reader, and owns song selection, rewind and auto-advance.

Parameters:
N_SONGS, 4, number of songs in ROM; valid song indices are 0..N_SONGS-1; must satisfy N_SONGS <= 2^SONG_BITS
SONG_BITS, 2, width of song-select bus

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; forces the reset state immediately
play_pause  input  1  single-cycle pulse; toggle play/pause
next  input  1  single-cycle pulse; skip to next song
prev  input  1  single-cycle pulse; skip to previous song
song_done  input  1  from song reader; high for ≥1 cycle when current song has ended
continuous  input  1  level; 1 = auto-advance on song_done, 0 = rewind and stop
play  output  1  level; 1 = reader/player run
reset_player  output  1  synchronous reset to song reader and note player
song  output  SONG_BITS  current song index

Behaviour:
- One clock; reset asynchronous active-high.
- States: RESET_PLAY, PAUSED, PLAYING, NEXT_SONG, PREV_SONG. One register: resume (1 bit).
- Moore outputs:
  - play = (state == PLAYING)
  - reset_player = (state == RESET_PLAY)
  - song = song register
- While reset is asserted: state = RESET_PLAY, song = 0, resume = 0. So play = 0 and reset_player = 1 during reset and for exactly 1 cycle after release, then PAUSED.
- RESET_PLAY: next state is PLAYING if resume = 1, else PAUSED. Inputs are ignored in this state. Always lasts exactly 1 cycle.
- PAUSED, priority next > prev > play_pause:
  - next -> NEXT_SONG, resume = 0
  - prev -> PREV_SONG, resume = 0
  - play_pause -> PLAYING; no reset, so the song resumes where it stopped
  - song_done is ignored in PAUSED.
- PLAYING, priority song_done > next > prev > play_pause:
  - song_done & continuous -> NEXT_SONG, resume = 1
  - song_done & ~continuous -> RESET_PLAY, resume = 0; song is unchanged (rewind and stop)
  - next -> NEXT_SONG, resume = 1
  - prev -> PREV_SONG, resume = 1
  - play_pause -> PAUSED; play drops the next cycle and the reader holds its position
- NEXT_SONG: song <= (song == N_SONGS-1) ? 0 : song+1. Then go to RESET_PLAY. Lasts 1 cycle.
- PREV_SONG: song <= (song == 0) ? N_SONGS-1 : song-1. Then go to RESET_PLAY. Lasts 1 cycle.
- The song register updates on the edge leaving NEXT_SONG/PREV_SONG. The new index is therefore stable during the RESET_PLAY cycle, so the reader address counter clears with the new song selected.
- Latency from a button pulse sampled at edge t in PLAYING:
  - t+1: NEXT_SONG/PREV_SONG, play = 0
  - t+2: RESET_PLAY, new song, reset_player = 1
  - t+3: PLAYING, play = 1
- Button pulses arriving in NEXT_SONG, PREV_SONG or RESET_PLAY are dropped; there is no queuing.
- song_done held high across the sequence does not cause a double advance. During RESET_PLAY the reader is reset, and song_done is ignored outside PLAYING. The reader must deassert song_done while in reset.
- Reset asserted mid-sequence (any state) returns to RESET_PLAY immediately; song = 0, resume = 0.
- The state encoding must be safe: any illegal state -> RESET_PLAY next cycle.

Test Plan:
- Reset release, no inputs -> reset_player = 1 for 1 cycle after release, then play = 0, song = 0, state PAUSED held indefinitely.
- PAUSED, play_pause pulse -> play = 1 next cycle, reset_player stays 0. Second play_pause pulse -> play = 0 next cycle, song unchanged.
- PLAYING song = 3 (N_SONGS = 4), next pulse:
  - next cycle: play = 0
  - cycle after: song = 0, reset_player = 1
  - cycle after that: play = 1
- PAUSED song = 0, prev pulse -> song = 3, one reset_player cycle, then play = 0 (stays paused).
- PLAYING song = 1, continuous = 1, song_done held 3 cycles -> song = 2 exactly once, one reset_player pulse, play = 1 again. With continuous = 0 -> song stays 1, reset_player pulse, play = 0.
- Simultaneous song_done + next + play_pause in PLAYING -> song_done path only, with exactly +1 advance. Then assert reset during NEXT_SONG -> song = 0, play = 0, reset_player = 1 immediately (asynchronous).
